// File: rtl/reaction_timer_core.sv
// Reaction-time game core: pseudo-random ARMED delay, then a BCD tenths
// counter that runs from GO until the player presses stop.
module reaction_timer_core #(
  parameter int         MIN_DELAY = 10,
  parameter int         RAND_BITS = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       go,
  output logic       foul,
  output logic       timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FOUL  = 3'd4
  } state_t;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [7:0] MIN8  = 8'(MIN_DELAY);
  localparam logic [7:0] MASK  = 8'((1 << RAND_BITS) - 1);

  state_t     st_q, st_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       go_q, go_d;
  logic       foul_q, foul_d;
  logic       to_q, to_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] load_val;
  logic       at_99;

  // Masking (rather than slicing) keeps RAND_BITS=0 legal: no random part.
  assign load_val = MIN8 + (lfsr_q & MASK);
  assign lfsr_d   = {lfsr_q[6:0],
                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign at_99    = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      tens_q <= BLANK;
      ones_q <= BLANK;
      go_q   <= 1'b0;
      foul_q <= 1'b0;
      to_q   <= 1'b0;
      dly_q  <= 8'd0;
      lfsr_q <= LFSR_SEED;
    end else begin
      st_q   <= st_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      go_q   <= go_d;
      foul_q <= foul_d;
      to_q   <= to_d;
      dly_q  <= dly_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    tens_d = tens_q;
    ones_d = ones_q;
    go_d   = go_q;
    foul_d = foul_q;
    to_d   = to_q;
    dly_d  = dly_q;
    if (clr) begin
      st_d   = IDLE;
      tens_d = BLANK;
      ones_d = BLANK;
      go_d   = 1'b0;
      foul_d = 1'b0;
      to_d   = 1'b0;
    end else begin
      unique case (st_q)
        IDLE, DONE, FOUL: begin
          if (start) begin
            st_d   = ARMED;
            dly_d  = load_val;
            tens_d = BLANK;
            ones_d = BLANK;
            go_d   = 1'b0;
            foul_d = 1'b0;
            to_d   = 1'b0;
          end
        end
        ARMED: begin
          if (stop) begin
            st_d   = FOUL;
            foul_d = 1'b1;
          end else if (tick) begin
            dly_d = dly_q - 8'd1;
            if (dly_q == 8'd1) begin
              st_d   = RUN;
              tens_d = 4'd0;
              ones_d = 4'd0;
              go_d   = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            st_d = DONE;
            go_d = 1'b0;
          end else if (tick) begin
            unique case (1'b1)
              at_99: begin
                st_d = DONE;
                go_d = 1'b0;
                to_d = 1'b1;
              end
              (!at_99 && ones_q == 4'd9): begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
              end
              default: ones_d = ones_q + 4'd1;
            endcase
          end
        end
        default: begin
          st_d   = IDLE;
          tens_d = BLANK;
          ones_d = BLANK;
          go_d   = 1'b0;
          foul_d = 1'b0;
          to_d   = 1'b0;
        end
      endcase
    end
  end

  assign state   = st_q;
  assign tens    = tens_q;
  assign ones    = ones_q;
  assign go      = go_q;
  assign foul    = foul_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: a default instance and a fixed-delay
// instance, both tracked every cycle by a count-based game model.
module tb_reaction_timer_core;

  logic clk = 1'b0;
  logic rst_n, tick, start, stop, clr;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic go0, foul0, to0, go1, foul1, to1;
  logic [2:0] st0, st1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reaction_timer_core u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .stop(stop), .clr(clr), .tens(tens0), .ones(ones0),
    .go(go0), .foul(foul0), .timeout(to0), .state(st0)
  );

  reaction_timer_core #(
    .MIN_DELAY(3), .RAND_BITS(0), .LFSR_SEED(8'hA5)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .stop(stop), .clr(clr), .tens(tens1), .ones(ones1),
    .go(go1), .foul(foul1), .timeout(to1), .state(st1)
  );

  // Model: the elapsed count is a plain integer (-1 = blank display).
  typedef struct {
    int       st;
    int       cnt;
    bit       go;
    bit       foul;
    bit       to;
    int       dly;
    bit [7:0] lfsr;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, int mn, int rb);
    mdl_t r = m;
    bit [7:0] nl;
    if (!rst_n) begin
      r.st = 0; r.cnt = -1; r.go = 0; r.foul = 0; r.to = 0;
      r.dly = 0; r.lfsr = 8'hA5;
      return r;
    end
    nl = {m.lfsr[6:0], ^(m.lfsr & 8'hB8)};
    if (clr) begin
      r.st = 0; r.cnt = -1; r.go = 0; r.foul = 0; r.to = 0;
    end else if (m.st == 0 || m.st == 3 || m.st == 4) begin
      if (start) begin
        r.st = 1; r.cnt = -1; r.go = 0; r.foul = 0; r.to = 0;
        r.dly = mn + (int'(m.lfsr) % (1 << rb));
      end
    end else if (m.st == 1) begin
      if (stop) begin
        r.st = 4; r.foul = 1;
      end else if (tick) begin
        if (m.dly == 1) begin
          r.st = 2; r.cnt = 0; r.go = 1;
        end
        r.dly = m.dly - 1;
      end
    end else if (m.st == 2) begin
      if (stop) begin
        r.st = 3; r.go = 0;
      end else if (tick) begin
        if (m.cnt == 99) begin
          r.st = 3; r.go = 0; r.to = 1;
        end else r.cnt = m.cnt + 1;
      end
    end
    r.lfsr = nl;
    return r;
  endfunction

  function automatic logic [13:0] view(mdl_t m);
    logic [3:0] t, o;
    t = (m.cnt < 0) ? 4'hF : 4'(m.cnt / 10);
    o = (m.cnt < 0) ? 4'hF : 4'(m.cnt % 10);
    return {3'(m.st), t, o, m.go, m.foul, m.to};
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, 10, 5);
    m1 = step(m1, 3, 0);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dut_vs_model",
          int'({st0, tens0, ones0, go0, foul0, to0}), int'(view(m0)));
      chk("fix_vs_model",
          int'({st1, tens1, ones1, go1, foul1, to1}), int'(view(m1)));
    end
  end

  task automatic cyc(input bit t, input bit s, input bit p, input bit c);
    tick = t; start = s; stop = p; clr = c;
    @(posedge clk);
    #1;
    tick = 0; start = 0; stop = 0; clr = 0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  int dl[8];
  int n;
  bit same;

  initial begin
    rst_n = 0; tick = 0; stop = 0; clr = 0; start = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", st0, 0);
    chk("rst_tens", tens0, 4'hF);
    chk("rst_ones", ones0, 4'hF);
    chk("rst_go", go0, 0);
    chk("rst_lfsr", u_dut.lfsr_q, 8'hA5);
    start = 0;
    rst_n = 1;
    cmp_en = 1;

    cyc(0, 1, 0, 0);
    chk("fix_armed", st1, 1);
    run_ticks(2);
    chk("fix_still_armed", st1, 1);
    run_ticks(1);
    chk("fix_run", st1, 2);
    chk("fix_go", go1, 1);
    run_ticks(12);
    cyc(0, 0, 1, 0);
    chk("fix_done", st1, 3);
    chk("fix_12", {tens1, ones1}, 8'h12);
    chk("fix_go_off", go1, 0);

    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    run_ticks(2);
    cyc(0, 0, 1, 0);
    chk("foul_state", st1, 4);
    chk("foul_flag", foul1, 1);
    chk("foul_blank", {tens1, ones1}, 8'hFF);
    cyc(0, 1, 0, 0);
    chk("foul_restart", st1, 1);
    chk("foul_clear", foul1, 0);

    run_ticks(3);
    run_ticks(99);
    chk("sat_99", {tens1, ones1}, 8'h99);
    chk("sat_run", st1, 2);
    run_ticks(1);
    chk("sat_done", st1, 3);
    chk("sat_timeout", to1, 1);
    chk("sat_hold", {tens1, ones1}, 8'h99);
    run_ticks(5);
    chk("sat_still", {st1, tens1, ones1, to1}, {3'd3, 8'h99, 1'b1});

    cyc(0, 1, 0, 0);
    run_ticks(3);
    run_ticks(9);
    chk("col_09", {tens1, ones1}, 8'h09);
    cyc(1, 0, 1, 0);
    chk("col_done", st1, 3);
    chk("col_hold", {tens1, ones1}, 8'h09);
    cyc(0, 1, 0, 1);
    chk("col_clr", st1, 0);
    chk("col_blank", {tens1, ones1}, 8'hFF);

    for (int r = 0; r < 8; r++) begin
      cyc(0, 0, 0, 1);
      repeat ($urandom_range(0, 15)) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      n = 0;
      while (!go0 && n < 300) begin
        cyc(1, 0, 0, 0);
        n++;
      end
      dl[r] = n;
      chk("delay_in_range", int'(n >= 10 && n <= 41), 1);
    end
    same = 1;
    for (int r = 1; r < 8; r++) if (dl[r] != dl[0]) same = 0;
    chk("delays_vary", int'(same), 0);

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
      rst_n = 1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
